// File: rtl/spi_ram_ctrl.sv
// Command-decoding RAM behind the SPI slave: address/data commands with
// auto-incrementing pointers and a tracker that rejects data before address.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       seq_err
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic {W_NOADDR, W_READY} wtrk_e;
    typedef enum logic {R_NOADDR, R_READY} rtrk_e;

    logic [7:0] mem [MEM_DEPTH];

    cmd_e                 cmd;
    wtrk_e                wtrk_q, wtrk_d;
    rtrk_e                rtrk_q, rtrk_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]           dout_q, dout_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 seq_err_q, seq_err_d;
    logic                 mem_we;

    assign cmd = cmd_e'(din[9:8]);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        wtrk_d     = wtrk_q;
        rtrk_d     = rtrk_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        dout_d     = dout_q;
        tx_valid_d = 1'b0;
        seq_err_d  = 1'b0;
        mem_we     = 1'b0;

        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_d = din[ADDR_SIZE-1:0];
                    wtrk_d    = W_READY;
                end
                CMD_WR_DATA: begin
                    if (wtrk_q == W_READY) begin
                        mem_we    = 1'b1;
                        wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_d = din[ADDR_SIZE-1:0];
                    rtrk_d    = R_READY;
                end
                CMD_RD_DATA: begin
                    if (rtrk_q == R_READY) begin
                        dout_d     = mem[rd_addr_q];
                        tx_valid_d = 1'b1;
                        rd_addr_d  = rd_addr_q + ADDR_SIZE'(1);
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wtrk_q     <= W_NOADDR;
            rtrk_q     <= R_NOADDR;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            dout_q     <= 8'h00;
            tx_valid_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            wtrk_q     <= wtrk_d;
            rtrk_q     <= rtrk_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            seq_err_q  <= seq_err_d;
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM; contents survive
    // rst_n and are only defined once written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= din[7:0];
        end
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign seq_err  = seq_err_q;

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Single-port 8-bit RAM with a command decoder that consumes the 10-bit words produced by the SPI slave (`rx_data`/`rx_valid`) and returns read bytes to it (`tx_data`/`tx_valid`). Sits directly downstream of the SPI slave in the SPI-with-RAM top level. Two address pointers auto-increment on every data access, so burst transfers need only one address command. A small protocol tracker flags data commands issued before any matching address command.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words; a power of two, at least 2.
- `ADDR_SIZE`, 8: address width; equals log2(`MEM_DEPTH`).
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `din`  input  10  command word from the SPI slave `rx_data`: [9:8] opcode, [7:0] payload.
- `rx_valid`  input  1  `din` is valid this cycle; one command is consumed per cycle while high.
- `dout`  output  8  read byte to the SPI slave `tx_data`.
- `tx_valid`  output  1  one-cycle pulse: `dout` holds a fresh read byte.
- `seq_err`  output  1  one-cycle pulse: the data command in the previous cycle was rejected.

## Operation
- Reset, asynchronous: `wr_addr`=0, `rd_addr`=0, `wa_vld`=0, `ra_vld`=0, `dout`=8'h00, `tx_valid`=0, `seq_err`=0. Memory contents are not reset.
- When `rx_valid`=0 there are no state changes. `tx_valid` and `seq_err` return to 0, and `dout` holds its value.
- When `rx_valid`=1, the block decodes `din[9:8]`:
  - 2'b00, WR_ADDR: `wr_addr` <= `din[ADDR_SIZE-1:0]`; `wa_vld` <= 1.
  - 2'b01, WR_DATA:
    - If `wa_vld`=1: `mem[wr_addr]` <= `din[7:0]`, then `wr_addr` <= `wr_addr`+1.
    - If `wa_vld`=0: no write, no increment; `seq_err` <= 1.
  - 2'b10, RD_ADDR: `rd_addr` <= `din[ADDR_SIZE-1:0]`; `ra_vld` <= 1.
  - 2'b11, RD_DATA:
    - If `ra_vld`=1: `dout` <= `mem[rd_addr]`, `tx_valid` <= 1, then `rd_addr` <= `rd_addr`+1.
    - If `ra_vld`=0: `dout` is unchanged, `tx_valid` stays 0, no increment; `seq_err` <= 1.
- Pointer arithmetic is modulo `MEM_DEPTH`: `MEM_DEPTH`-1 increments to 0 with no flag. The pointers are `ADDR_SIZE` bits wide, and `din` bits above `ADDR_SIZE`-1 are ignored.
- Once set, `wa_vld` and `ra_vld` stay set until reset. A new address command simply reloads its pointer.
- The write and read pointers are independent; a write never moves `rd_addr`, and a read never moves `wr_addr`.
- Protocol tracker, described as two independent 2-state FSMs:
  - Write tracker: W_NOADDR to W_READY on WR_ADDR; W_READY is absorbing.
  - Read tracker: R_NOADDR to R_READY on RD_ADDR; R_READY is absorbing.
  - Reset from any state returns both trackers to their NOADDR state.

## Timing
- Write latency: WR_DATA sampled at edge N updates memory at edge N. A RD_DATA to the same address, sampled at edge N+1 or later, returns the new byte.
- Read latency: RD_DATA sampled at edge N makes `dout` valid and `tx_valid`=1 in the cycle after edge N. `tx_valid` drops at edge N+1 unless another RD_DATA is sampled at N+1.
- Back-to-back RD_DATA commands produce consecutive `tx_valid` cycles, with `dout` stepping through consecutive addresses.
- `seq_err` asserts in the cycle after the rejected command and lasts one cycle per rejected command.
- Asynchronous reset asserted mid-burst: all outputs go to their reset values immediately, without waiting for a clock edge. After release, the first data command of either kind is rejected until its address command arrives.
- There is no backpressure; the upstream SPI slave guarantees that `rx_valid` pulses fit the command rate.

## Test plan
- Reset then write/read: {00,0x10}, {01,0xA5}, {10,0x10}, {11,xx} -> `tx_valid` pulses once, `dout`=0xA5, `seq_err` never asserts.
- Burst auto-increment: WR_ADDR 0x20, then WR_DATA 0x11/0x22/0x33; RD_ADDR 0x20, then three back-to-back RD_DATA -> three consecutive `tx_valid` cycles with `dout`=0x11, 0x22, 0x33. The pointers finish at 0x23.
- Wrap-around: WR_ADDR 0xFF, WR_DATA 0x5A, WR_DATA 0xC3; RD_ADDR 0xFF, RD_DATA ×2 -> `dout`=0x5A then 0xC3. The second value was read from address 0x00.
- Sequence errors after reset: WR_DATA 0x77 then RD_DATA -> two `seq_err` pulses, `tx_valid`=0, `dout`=0x00. `mem[0]` is not 0x77; check via WR_ADDR 0 / RD_ADDR 0 / RD_DATA against the preload.
- Idle gaps: `rx_valid` low for 5 cycles between RD_ADDR and RD_DATA -> no output activity in the gap, and the read is still correct one cycle after RD_DATA.
- Reset mid-burst: assert `rst_n`=0 between two RD_DATA commands -> `tx_valid` and `dout` clear asynchronously. A RD_DATA after release raises `seq_err` and produces no `tx_valid`.
